pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: INIT/RUN/STALL sequencing, load-use stall,
// EX/MEM/WB operand forwarding and saturating stall/branch event counters.
module pipeline_hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_branch_taken,
  input  logic       ex_load_instr,
  input  logic       ex_rf_enable,
  input  logic [4:0] ex_rd,
  input  logic       mem_rf_enable,
  input  logic [4:0] mem_rd,
  input  logic       wb_rf_enable,
  input  logic [4:0] wb_rd,
  output logic       pc_ld,
  output logic       npc_ld,
  output logic       ifid_ld,
  output logic       nop_sel,
  output logic       tgt_sel,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic [1:0] state,
  output logic [7:0] stall_cnt,
  output logic [7:0] branch_cnt
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10
  } state_t;

  state_t     state_reg, state_next;
  logic       fill_reg, fill_next;
  logic [7:0] stall_cnt_reg, branch_cnt_reg;

  logic luh;
  logic loads;
  logic fwd_en;
  logic stall_evt;

  // A load whose result is needed by the instruction directly behind it.
  always_comb begin
    luh = ex_load_instr && ex_rf_enable && (ex_rd != 5'd0) &&
          ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
  end

  // While reset is held low the outputs behave as INIT, whatever the state register holds.
  always_comb begin
    loads      = 1'b1;
    nop_sel    = 1'b1;
    tgt_sel    = 1'b0;
    fwd_en     = 1'b0;
    stall_evt  = 1'b0;
    state_next = ST_INIT;
    fill_next  = 1'b0;
    if (reset) begin
      case (state_reg)
        ST_INIT: begin
          fill_next  = !fill_reg;
          state_next = fill_reg ? ST_RUN : ST_INIT;
        end
        ST_RUN: begin
          fwd_en = 1'b1;
          if (luh) begin
            loads      = 1'b0;
            stall_evt  = 1'b1;
            state_next = ST_STALL;
          end else begin
            nop_sel    = 1'b0;
            tgt_sel    = id_branch_taken;
            state_next = ST_RUN;
          end
        end
        ST_STALL: begin
          // The bubble is already in flight, so luh is deliberately ignored here.
          fwd_en     = 1'b1;
          nop_sel    = 1'b0;
          tgt_sel    = id_branch_taken;
          state_next = ST_RUN;
        end
        default: begin
          state_next = ST_INIT;
        end
      endcase
    end
  end

  assign pc_ld   = loads;
  assign npc_ld  = loads;
  assign ifid_ld = loads;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [4:0] src;
      logic       uses;
      logic [1:0] sel;

      if (gi == 0) begin : g_src_rs
        assign src  = id_rs;
        assign uses = id_uses_rs;
      end else begin : g_src_rt
        assign src  = id_rt;
        assign uses = id_uses_rt;
      end

      // Youngest producer wins; r0 is hard-wired zero and never forwarded.
      always_comb begin
        sel = 2'b00;
        if (fwd_en && uses && (src != 5'd0)) begin
          if (ex_rf_enable && !ex_load_instr && (ex_rd == src))
            sel = 2'b01;
          else if (mem_rf_enable && (mem_rd == src))
            sel = 2'b10;
          else if (wb_rf_enable && (wb_rd == src))
            sel = 2'b11;
        end
      end
    end
  endgenerate

  assign fwd_a = g_fwd[0].sel;
  assign fwd_b = g_fwd[1].sel;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= ST_INIT;
      fill_reg       <= 1'b0;
      stall_cnt_reg  <= 8'd0;
      branch_cnt_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      fill_reg  <= fill_next;
      if (stall_evt && (stall_cnt_reg != 8'hFF))
        stall_cnt_reg <= stall_cnt_reg + 8'd1;
      if (tgt_sel && (branch_cnt_reg != 8'hFF))
        branch_cnt_reg <= branch_cnt_reg + 8'd1;
    end
  end

  assign state      = state_reg;
  assign stall_cnt  = stall_cnt_reg;
  assign branch_cnt = branch_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: expected control word and counters
// are queued as each cycle's stimulus is driven and compared at the falling edge.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt;
  logic       id_uses_rs, id_uses_rt, id_branch_taken;
  logic       ex_load_instr, ex_rf_enable;
  logic [4:0] ex_rd;
  logic       mem_rf_enable;
  logic [4:0] mem_rd;
  logic       wb_rf_enable;
  logic [4:0] wb_rd;
  logic       pc_ld, npc_ld, ifid_ld, nop_sel, tgt_sel;
  logic [1:0] fwd_a, fwd_b, state;
  logic [7:0] stall_cnt, branch_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_branch_taken(id_branch_taken),
    .ex_load_instr(ex_load_instr), .ex_rf_enable(ex_rf_enable), .ex_rd(ex_rd),
    .mem_rf_enable(mem_rf_enable), .mem_rd(mem_rd),
    .wb_rf_enable(wb_rf_enable), .wb_rd(wb_rd),
    .pc_ld(pc_ld), .npc_ld(npc_ld), .ifid_ld(ifid_ld),
    .nop_sel(nop_sel), .tgt_sel(tgt_sel),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
    .stall_cnt(stall_cnt), .branch_cnt(branch_cnt)
  );

  typedef struct {
    string       tag;
    logic [26:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   passed = 0;
  int   m_sc = 0;
  int   m_bc = 0;

  localparam logic [1:0] S_INIT = 2'b00, S_RUN = 2'b01, S_STALL = 2'b10;

  function automatic logic [10:0] ctl(input logic [1:0] st, input logic ld, input logic nop,
                                      input logic tgt, input logic [1:0] fa, input logic [1:0] fb);
    return {st, ld, ld, ld, nop, tgt, fa, fb};
  endfunction

  function automatic logic [26:0] observed();
    return {state, pc_ld, npc_ld, ifid_ld, nop_sel, tgt_sel, fwd_a, fwd_b, stall_cnt, branch_cnt};
  endfunction

  // Queue the expectation for this cycle, then advance the counter model across the coming edge.
  task automatic push_exp(input string tag, input logic [10:0] c);
    exp_t x;
    x.tag = tag;
    x.val = {c, 8'(m_sc), 8'(m_bc)};
    sb.push_back(x);
    if (!reset) begin
      m_sc = 0;
      m_bc = 0;
    end else begin
      if (c[10:9] == S_RUN && c[5] && m_sc < 255) m_sc++;
      if (c[4] && m_bc < 255) m_bc++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_branch_taken = 1'b0; ex_load_instr = 1'b0; ex_rf_enable = 1'b0; ex_rd = 5'd0;
    mem_rf_enable = 1'b0; mem_rd = 5'd0; wb_rf_enable = 1'b0; wb_rd = 5'd0;
  endtask

  task automatic load_use(input logic [4:0] r, input logic via_rt);
    ex_load_instr = 1'b1; ex_rf_enable = 1'b1; ex_rd = r;
    id_uses_rs = !via_rt; id_rs = via_rt ? 5'd0 : r;
    id_uses_rt = via_rt;  id_rt = via_rt ? r : 5'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    id_uses_rs = 1'b1; id_rs = 5'd3; mem_rf_enable = 1'b1; mem_rd = 5'd3;
    step(); step();
    push_exp("reset_hold", ctl(S_INIT, 1, 1, 0, 2'b00, 2'b00));
    @(negedge clk); e = sb.pop_front(); checks++;
    if (observed() !== e.val) $display("FAIL %s: got %h expected %h", e.tag, observed(), e.val); else passed++;
    step();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_exp($sformatf("init_cycle%0d", i), ctl(S_INIT, 1, 1, 0, 2'b00, 2'b00));
      @(negedge clk); e = sb.pop_front(); checks++;
      if (observed() !== e.val) $display("FAIL %s: got %h expected %h", e.tag, observed(), e.val); else passed++;
      step();
    end
    push_exp("first_run", ctl(S_RUN, 1, 0, 0, 2'b10, 2'b00));
    @(negedge clk); e = sb.pop_front(); checks++;
    if (observed() !== e.val) $display("FAIL %s: got %h expected %h", e.tag, observed(), e.val); else passed++;
    step();
    idle();
  endtask

  task automatic test_load_use();
    load_use(5'd5, 1'b0);
    push_exp("lu_stall", ctl(S_RUN, 0, 1, 0, 2'b00, 2'b00));
    @(negedge clk); e = sb.pop_front(); checks++;
    if (observed() !== e.val) $display("FAIL %s: got %h expected %h", e.tag, observed(), e.val); else passed++;
    step();
    push_exp("lu_bubble", ctl(S_STALL, 1, 0, 0, 2'b00, 2'b00));
    @(negedge clk); e = sb.pop_front(); checks++;
    if (observed() !== e.val) $display("FAIL %s: got %h expected %h", e.tag, observed(), e.val); else passed++;
    step();
    idle();
    push_exp("lu_resume", ctl(S_RUN, 1, 0, 0, 2'b00, 2'b00));
    @(negedge clk); e = sb.pop_front(); checks++;
    if (observed() !== e.val) $display("FAIL %s: got %h expected %h", e.tag, observed(), e.val); else passed++;
    step();
  endtask

  task automatic test_no_stall();
    // r0 destination, disabled write, and an unread operand must not stall.
    for (int i = 0; i < 3; i++) begin
      load_use(5'd0, 1'b0);
      if (i == 1) begin load_use(5'd5, 1'b0); ex_rf_enable = 1'b0; end
      if (i == 2) begin load_use(5'd6, 1'b1); id_uses_rt = 1'b0; end
      push_exp($sformatf("no_stall%0d", i), ctl(S_RUN, 1, 0, 0, 2'b00, 2'b00));
      @(negedge clk); e = sb.pop_front(); checks++;
      if (observed() !== e.val) $display("FAIL %s: got %h expected %h", e.tag, observed(), e.val); else passed++;
      step();
    end
    idle();
  endtask

  task automatic test_forwarding();
    logic [1:0] exp_sel [4];
    exp_sel[0] = 2'b01; exp_sel[1] = 2'b10; exp_sel[2] = 2'b11; exp_sel[3] = 2'b00;
    id_rs = 5'd7; id_rt = 5'd7; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
    ex_rf_enable = 1'b1; ex_rd = 5'd7; mem_rf_enable = 1'b1; mem_rd = 5'd7;
    wb_rf_enable = 1'b1; wb_rd = 5'd7;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) ex_rf_enable = 1'b0;
      if (i == 2) mem_rf_enable = 1'b0;
      if (i == 3) wb_rf_enable = 1'b0;
      push_exp($sformatf("fwd_prio%0d", i), ctl(S_RUN, 1, 0, 0, exp_sel[i], exp_sel[i]));
      @(negedge clk); e = sb.pop_front(); checks++;
      if (observed() !== e.val) $display("FAIL %s: got %h expected %h", e.tag, observed(), e.val); else passed++;
      step();
    end
    id_rs = 5'd7; id_rt = 5'd8; ex_rf_enable = 1'b1; ex_rd = 5'd3;
    mem_rf_enable = 1'b1; mem_rd = 5'd7; wb_rf_enable = 1'b1; wb_rd = 5'd8;
    push_exp("fwd_mixed", ctl(S_RUN, 1, 0, 0, 2'b10, 2'b11));
    @(negedge clk); e = sb.pop_front(); checks++;
    if (observed() !== e.val) $display("FAIL %s: got %h expected %h", e.tag, observed(), e.val); else passed++;
    step();
    id_uses_rt = 1'b0; ex_rd = 5'd7;
    push_exp("fwd_unused_rt", ctl(S_RUN, 1, 0, 0, 2'b01, 2'b00));
    @(negedge clk); e = sb.pop_front(); checks++;
    if (observed() !== e.val) $display("FAIL %s: got %h expected %h", e.tag, observed(), e.val); else passed++;
    step();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1; ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
    push_exp("fwd_r0", ctl(S_RUN, 1, 0, 0, 2'b00, 2'b00));
    @(negedge clk); e = sb.pop_front(); checks++;
    if (observed() !== e.val) $display("FAIL %s: got %h expected %h", e.tag, observed(), e.val); else passed++;
    step();
    idle();
  endtask

  task automatic test_branch_stall();
    load_use(5'd4, 1'b0);
    id_branch_taken = 1'b1;
    push_exp("br_stall", ctl(S_RUN, 0, 1, 0, 2'b00, 2'b00));
    @(negedge clk); e = sb.pop_front(); checks++;
    if (observed() !== e.val) $display("FAIL %s: got %h expected %h", e.tag, observed(), e.val); else passed++;
    step();
    push_exp("br_in_stall", ctl(S_STALL, 1, 0, 1, 2'b00, 2'b00));
    @(negedge clk); e = sb.pop_front(); checks++;
    if (observed() !== e.val) $display("FAIL %s: got %h expected %h", e.tag, observed(), e.val); else passed++;
    step();
    idle();
    id_branch_taken = 1'b1;
    push_exp("br_run", ctl(S_RUN, 1, 0, 1, 2'b00, 2'b00));
    @(negedge clk); e = sb.pop_front(); checks++;
    if (observed() !== e.val) $display("FAIL %s: got %h expected %h", e.tag, observed(), e.val); else passed++;
    step();
    idle();
    push_exp("br_after", ctl(S_RUN, 1, 0, 0, 2'b00, 2'b00));
    @(negedge clk); e = sb.pop_front(); checks++;
    if (observed() !== e.val) $display("FAIL %s: got %h expected %h", e.tag, observed(), e.val); else passed++;
    step();
  endtask

  task automatic test_back_to_back();
    // Hazard held across the bubble: each RUN cycle stalls, each STALL cycle does not.
    for (int i = 0; i < 4; i++) begin
      load_use(5'd9, i[1]);
      if (i[0] == 1'b0)
        push_exp($sformatf("b2b%0d", i), ctl(S_RUN, 0, 1, 0, 2'b00, 2'b00));
      else
        push_exp($sformatf("b2b%0d", i), ctl(S_STALL, 1, 0, 0, 2'b00, 2'b00));
      @(negedge clk); e = sb.pop_front(); checks++;
      if (observed() !== e.val) $display("FAIL %s: got %h expected %h", e.tag, observed(), e.val); else passed++;
      step();
    end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    load_use(5'd2, 1'b0);
    push_exp("mid_enter", ctl(S_RUN, 0, 1, 0, 2'b00, 2'b00));
    @(negedge clk); e = sb.pop_front(); checks++;
    if (observed() !== e.val) $display("FAIL %s: got %h expected %h", e.tag, observed(), e.val); else passed++;
    step();
    reset = 1'b0;
    id_branch_taken = 1'b1; mem_rf_enable = 1'b1; mem_rd = 5'd2;
    push_exp("mid_reset", ctl(S_STALL, 1, 1, 0, 2'b00, 2'b00));
    @(negedge clk); e = sb.pop_front(); checks++;
    if (observed() !== e.val) $display("FAIL %s: got %h expected %h", e.tag, observed(), e.val); else passed++;
    step();
    reset = 1'b1;
    idle();
    for (int i = 0; i < 2; i++) begin
      push_exp($sformatf("mid_init%0d", i), ctl(S_INIT, 1, 1, 0, 2'b00, 2'b00));
      @(negedge clk); e = sb.pop_front(); checks++;
      if (observed() !== e.val) $display("FAIL %s: got %h expected %h", e.tag, observed(), e.val); else passed++;
      step();
    end
    push_exp("mid_run", ctl(S_RUN, 1, 0, 0, 2'b00, 2'b00));
    @(negedge clk); e = sb.pop_front(); checks++;
    if (observed() !== e.val) $display("FAIL %s: got %h expected %h", e.tag, observed(), e.val); else passed++;
    step();
  endtask

  task automatic test_saturation();
    load_use(5'd11, 1'b0);
    for (int i = 0; i < 600; i++) begin
      if (i % 2 == 0)
        push_exp($sformatf("sat%0d", i), ctl(S_RUN, 0, 1, 0, 2'b00, 2'b00));
      else
        push_exp($sformatf("sat%0d", i), ctl(S_STALL, 1, 0, 0, 2'b00, 2'b00));
      @(negedge clk); e = sb.pop_front(); checks++;
      if (observed() !== e.val) $display("FAIL %s: got %h expected %h", e.tag, observed(), e.val); else passed++;
      step();
    end
    idle();
    push_exp("sat_hold", ctl(S_RUN, 1, 0, 0, 2'b00, 2'b00));
    @(negedge clk); e = sb.pop_front(); checks++;
    if (observed() !== e.val) $display("FAIL %s: got %h expected %h", e.tag, observed(), e.val); else passed++;
    checks++;
    if (stall_cnt !== 8'd255) $display("FAIL sat_value: got %0d expected 255", stall_cnt); else passed++;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_no_stall();
    test_forwarding();
    test_branch_stall();
    test_back_to_back();
    test_reset_mid_stall();
    test_saturation();
    checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
